// File: rtl/adc045_pkg.sv
// adc045_pkg: shared definitions for the adc045_ctrl sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sample width, default bring-up/watchdog timing, FSM state
// encodings (exported on the 'state' debug port), counter-width helper.
package adc045_pkg;

  localparam int ADC045_DATA_W = 24;

  // Default timing in adc_clk cycles at 10 MHz.
  localparam int RST_PULSE_CYC_DEF = 1;
  localparam int RST_WAIT_CYC_DEF  = 4000;   // 400 us
  localparam int WREG_WAIT_CYC_DEF = 500;    // 50 us
  localparam int WDOG_CYC_DEF      = 128;    // nominal sample period is 39
  localparam int MAX_RETRY_DEF     = 3;

  // Fixed encodings so the debug port stays stable across builds.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RST_PULSE = 3'd1;
  localparam logic [2:0] RST_WAIT  = 3'd2;
  localparam logic [2:0] WREG      = 3'd3;
  localparam logic [2:0] WREG_WAIT = 3'd4;
  localparam logic [2:0] START     = 3'd5;
  localparam logic [2:0] RUN       = 3'd6;
  localparam logic [2:0] FAULT     = 3'd7;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/adc045_ctrl_timer.sv
// adc045_ctrl_timer: loadable down-counter, done while the count is zero.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts every cycle and parks at zero.
// Ports: clk, rst_l (async active-low), load/load_val (reload), done (count == 0).
module adc045_ctrl_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/adc045_ctrl.sv
// adc045_ctrl: brings up adc045_wrap (reset pulse, reg write, start), forwards samples, watchdog recovery.
// Latency: sample strobe 1 cycle after the ready_sample rising edge; control outputs registered.
// Backpressure: none; samples are strobed out unconditionally, en=0 aborts to IDLE in one cycle.
// Ports: clk, rst_l (async active-low), en, ready_sample, adc045_data[23:0] in;
//        rst_l_adc, hard_wreg, hard_start, smp_valid, smp_data[23:0], state[2:0],
//        fault, restart_cnt[7:0] out.
// Option: define ADC045_CTRL_DECIM_EN to add decim_n[7:0]; only every
//         (decim_n+1)-th capture is then forwarded.
module adc045_ctrl
  import adc045_pkg::*;
#(
  parameter int RST_PULSE_CYC = RST_PULSE_CYC_DEF,
  parameter int RST_WAIT_CYC  = RST_WAIT_CYC_DEF,
  parameter int WREG_WAIT_CYC = WREG_WAIT_CYC_DEF,
  parameter int WDOG_CYC      = WDOG_CYC_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     en,
  input  logic                     ready_sample,
  input  logic [ADC045_DATA_W-1:0] adc045_data,
`ifdef ADC045_CTRL_DECIM_EN
  input  logic [7:0]               decim_n,
`endif
  output logic                     rst_l_adc,
  output logic                     hard_wreg,
  output logic                     hard_start,
  output logic                     smp_valid,
  output logic [ADC045_DATA_W-1:0] smp_data,
  output logic [2:0]               state,
  output logic                     fault,
  output logic [7:0]               restart_cnt
);

  localparam int CNT_W = $clog2(max4(RST_PULSE_CYC, RST_WAIT_CYC,
                                     WREG_WAIT_CYC, WDOG_CYC)) + 1;
  localparam logic [7:0] MAX_RETRY_V = 8'(MAX_RETRY);

  logic             ready_q;
  logic             smp_edge;
  logic             capture;
  logic             fwd;
  logic [2:0]       nxt;
  logic             retry_inc;
  logic [7:0]       retry;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  // Level or pulse on ready_sample both reduce to one rising edge.
  assign smp_edge = ready_sample & ~ready_q;
  assign capture  = en && (state == RUN) && smp_edge;

  always_comb begin
    nxt       = state;
    retry_inc = 1'b0;
    if (!en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:      nxt = RST_PULSE;
        RST_PULSE: if (tmr_done) nxt = RST_WAIT;
        RST_WAIT:  if (tmr_done) nxt = WREG;
        WREG:      nxt = WREG_WAIT;
        WREG_WAIT: if (tmr_done) nxt = START;
        START:     nxt = RUN;
        RUN: begin
          // A sample arriving on the expiry cycle still counts as alive.
          if (!capture && tmr_done) begin
            if (retry < MAX_RETRY_V) begin
              nxt       = RST_PULSE;
              retry_inc = 1'b1;
            end else begin
              nxt = FAULT;
            end
          end
        end
        FAULT:     nxt = FAULT;
        default:   nxt = IDLE;
      endcase
    end
  end

  // One timer serves every timed state: it is loaded with (duration-1) on
  // state entry, and the watchdog is re-armed on every accepted edge.
  always_comb begin
    tmr_load = (nxt != state) || capture;
    tmr_val  = '0;
    case (nxt)
      RST_PULSE: tmr_val = CNT_W'(RST_PULSE_CYC - 1);
      RST_WAIT:  tmr_val = CNT_W'(RST_WAIT_CYC - 1);
      WREG_WAIT: tmr_val = CNT_W'(WREG_WAIT_CYC - 1);
      RUN:       tmr_val = CNT_W'(WDOG_CYC - 1);
      default:   tmr_val = '0;
    endcase
  end

  adc045_ctrl_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef ADC045_CTRL_DECIM_EN
  logic [7:0] phase;

  assign fwd = capture && (phase == decim_n);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      phase <= '0;
    end else if ((state != RUN) && (nxt == RUN)) begin
      phase <= '0;
    end else if (capture) begin
      phase <= (phase == decim_n) ? 8'd0 : phase + 8'd1;
    end
  end
`else
  assign fwd = capture;
`endif

  // Outputs are decoded from the next state so they line up with 'state'.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ready_q     <= 1'b0;
      state       <= IDLE;
      rst_l_adc   <= 1'b1;
      hard_wreg   <= 1'b0;
      hard_start  <= 1'b0;
      fault       <= 1'b0;
      smp_valid   <= 1'b0;
      smp_data    <= '0;
      retry       <= '0;
      restart_cnt <= '0;
    end else begin
      ready_q    <= ready_sample;
      state      <= nxt;
      rst_l_adc  <= (nxt != RST_PULSE);
      hard_wreg  <= (nxt == WREG);
      hard_start <= (nxt == START);
      fault      <= (nxt == FAULT);
      smp_valid  <= fwd;
      if (fwd) smp_data <= adc045_data;

      if (!en) begin
        retry       <= '0;
        restart_cnt <= '0;
      end else if (capture) begin
        retry <= '0;
      end else if (retry_inc) begin
        retry <= retry + 8'd1;
        if (restart_cnt != 8'hFF) restart_cnt <= restart_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc045_ctrl.sv
// tb_adc045_ctrl: directed bench for adc045_ctrl with a sample scoreboard.
module tb_adc045_ctrl;
  import adc045_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        en = 1'b0;
  logic        ready_sample = 1'b0;
  logic [23:0] adc045_data = 24'h0;
`ifdef ADC045_CTRL_DECIM_EN
  logic [7:0]  decim_n = 8'd0;
`endif
  logic        rst_l_adc, hard_wreg, hard_start, smp_valid, fault;
  logic [23:0] smp_data;
  logic [2:0]  state;
  logic [7:0]  restart_cnt;

  int          checks = 0;
  int          errors = 0;
  int          n_pushed = 0;
  int          n_strobes = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;

  always #5 clk = ~clk;

  adc045_ctrl dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .en           (en),
    .ready_sample (ready_sample),
    .adc045_data  (adc045_data),
`ifdef ADC045_CTRL_DECIM_EN
    .decim_n      (decim_n),
`endif
    .rst_l_adc    (rst_l_adc),
    .hard_wreg    (hard_wreg),
    .hard_start   (hard_start),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .state        (state),
    .fault        (fault),
    .restart_cnt  (restart_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every smp_valid strobe must match the oldest outstanding expected sample.
  always @(negedge clk) begin
    if (rst_l && smp_valid === 1'b1) begin
      n_strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL smp_unexpected actual=%0h required=no_strobe", smp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (smp_data !== mon_exp) begin
          errors++;
          $display("FAIL smp_data actual=%0h required=%0h", smp_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the edge that entered RST_PULSE (bring-up cycle 1);
  // returns in the first RUN cycle (cycle 4504).
  task automatic check_bringup(input string tag);
    logic [2:0] es;
    for (int c = 1; c <= 4504; c++) begin
      if (c > 1) tick();
      if (c == 1)         es = RST_PULSE;
      else if (c <= 4001) es = RST_WAIT;
      else if (c == 4002) es = WREG;
      else if (c <= 4502) es = WREG_WAIT;
      else if (c == 4503) es = START;
      else                es = RUN;
      chk({tag, "_seq"}, 32'({state, rst_l_adc, hard_wreg, hard_start}),
          32'({es, (c != 1), (c == 4002), (c == 4503)}));
    end
  endtask

  task automatic start_bringup(input string tag);
    en = 1'b1;
    tick();
    check_bringup(tag);
  endtask

  task automatic send_sample(input logic [23:0] data, input logic fwd, input int hold);
    adc045_data  = data;
    ready_sample = 1'b1;
    if (fwd) begin
      exp_q.push_back(data);
      n_pushed++;
    end
    tick();
    chk("smp_valid_latency", 32'(smp_valid), 32'(fwd));
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("smp_valid_level", 32'(smp_valid), 32'(0));
    end
    ready_sample = 1'b0;
    adc045_data  = 24'h5A5A5A;
  endtask

  // Called one step after the edge that last armed the watchdog.
  task automatic wait_timeout(input logic [2:0] exp_st, input logic [7:0] exp_cnt, input string tag);
    for (int k = 1; k <= 127; k++) tick();
    chk({tag, "_still_run"}, 32'(state), 32'(RUN));
    tick();
    chk({tag, "_state"}, 32'(state), 32'(exp_st));
    chk({tag, "_restart_cnt"}, 32'(restart_cnt), 32'(exp_cnt));
    chk({tag, "_rst_l_adc"}, 32'(rst_l_adc), 32'(exp_st != RST_PULSE));
    chk({tag, "_fault"}, 32'(fault), 32'(exp_st == FAULT));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rst_l_adc"}, 32'(rst_l_adc), 32'(1));
    chk({tag, "_hard_wreg"}, 32'(hard_wreg), 32'(0));
    chk({tag, "_hard_start"}, 32'(hard_start), 32'(0));
    chk({tag, "_smp_valid"}, 32'(smp_valid), 32'(0));
    chk({tag, "_smp_data"}, 32'(smp_data), 32'(0));
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
    chk({tag, "_fault"}, 32'(fault), 32'(0));
    chk({tag, "_restart_cnt"}, 32'(restart_cnt), 32'(0));
  endtask

  initial begin
    int wreg_seen;

    // Reset state
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    tick();
    chk("idle_hold", 32'(state), 32'(IDLE));

    // Bring-up timing from IDLE
    start_bringup("bringup1");

    // Capture: 3-cycle level gives one strobe, then a negative full-scale value
    tick();
    send_sample(24'h7FFFFF, 1'b1, 3);
    tick();
    tick();
    chk("smp_data_held1", 32'(smp_data), 32'h7FFFFF);
    send_sample(24'h800001, 1'b1, 1);
    tick();
    chk("smp_data_held2", 32'(smp_data), 32'h800001);

    // Watchdog restart, then a sample clears the retry budget
    send_sample(24'h000123, 1'b1, 1);
    wait_timeout(RST_PULSE, 8'd1, "wdog1");
    check_bringup("rebringup1");
    tick();
    send_sample(24'h00ABCD, 1'b1, 1);
    wait_timeout(RST_PULSE, 8'd2, "wdog2");
    check_bringup("rebringup2");
    wait_timeout(RST_PULSE, 8'd3, "wdog3");
    check_bringup("rebringup3");
    wait_timeout(RST_PULSE, 8'd4, "wdog4");
    check_bringup("rebringup4");
    wait_timeout(FAULT, 8'd4, "wdog_fault_a");
    tick();
    tick();
    chk("fault_sticky_state", 32'(state), 32'(FAULT));
    chk("fault_sticky_flag", 32'(fault), 32'(1));
    en = 1'b0;
    tick();
    chk("fault_clear_state", 32'(state), 32'(IDLE));
    chk("fault_clear_flag", 32'(fault), 32'(0));
    chk("fault_clear_cnt", 32'(restart_cnt), 32'(0));

    // Fault from a fresh start: four consecutive timeouts
    start_bringup("bringup2");
    wait_timeout(RST_PULSE, 8'd1, "fresh1");
    check_bringup("fresh_rb1");
    wait_timeout(RST_PULSE, 8'd2, "fresh2");
    check_bringup("fresh_rb2");
    wait_timeout(RST_PULSE, 8'd3, "fresh3");
    check_bringup("fresh_rb3");
    wait_timeout(FAULT, 8'd3, "fresh_fault");
    en = 1'b0;
    tick();
    chk("fresh_idle_state", 32'(state), 32'(IDLE));
    chk("fresh_idle_fault", 32'(fault), 32'(0));
    chk("fresh_idle_cnt", 32'(restart_cnt), 32'(0));

    // Abort during RST_WAIT: hard_wreg must never pulse
    en = 1'b1;
    tick();
    for (int c = 2; c <= 2000; c++) tick();
    chk("abort_in_rst_wait", 32'(state), 32'(RST_WAIT));
    en = 1'b0;
    tick();
    chk("abort_state", 32'(state), 32'(IDLE));
    chk("abort_rst_l_adc", 32'(rst_l_adc), 32'(1));
    wreg_seen = 0;
    for (int c = 0; c < 2200; c++) begin
      tick();
      if (hard_wreg === 1'b1) wreg_seen++;
    end
    chk("abort_no_wreg", 32'(wreg_seen), 32'(0));

    start_bringup("bringup3");
`ifdef ADC045_CTRL_DECIM_EN
    // Decimation by 4: only the 4th and 8th captures are forwarded
    decim_n = 8'd3;
    for (int i = 1; i <= 8; i++) begin
      send_sample(24'(i) + 24'h100, (i % 4) == 0, 1);
      tick();
    end
    chk("decim_smp_data", 32'(smp_data), 32'h108);
    chk("decim_state", 32'(state), 32'(RUN));
`endif

    // en=0 coinciding with an edge: IDLE wins, no strobe
    tick();
    adc045_data  = 24'h3C3C3C;
    ready_sample = 1'b1;
    en           = 1'b0;
    tick();
    chk("abort_edge_state", 32'(state), 32'(IDLE));
    chk("abort_edge_valid", 32'(smp_valid), 32'(0));
    ready_sample = 1'b0;
    tick();
    chk("abort_edge_valid2", 32'(smp_valid), 32'(0));

    // Asynchronous reset in RUN forces reset values without a clock edge
`ifdef ADC045_CTRL_DECIM_EN
    decim_n = 8'd0;
`endif
    start_bringup("bringup4");
    tick();
    send_sample(24'h654321, 1'b1, 1);
    tick();
    tick();
    chk("pre_rst_state", 32'(state), 32'(RUN));
    #3;
    rst_l = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_l = 1'b1;
    en    = 1'b0;
    tick();
    tick();

    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    chk("strobe_count", 32'(n_strobes), 32'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
